// File: rtl/wrr_stream_arbiter_pkg.sv
// Shared types and helpers for the packet-locked weighted round-robin stream arbiter.
package stream_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_STREAMS      = 32'd32;
  localparam int unsigned ONEHOT_IDX_W     = 32'd5;
  // A programmed weight of zero still earns one packet per round.
  localparam int unsigned WEIGHT_ZERO_LOAD = 32'd1;

  function automatic logic [ONEHOT_IDX_W-1:0] onehot_to_idx(input logic [MAX_STREAMS-1:0] onehot);
    logic [ONEHOT_IDX_W-1:0] idx;
    idx = {ONEHOT_IDX_W{1'b0}};
    for (int i = 0; i < int'(MAX_STREAMS); i++) begin
      idx = idx | (onehot[i] ? ONEHOT_IDX_W'(i) : {ONEHOT_IDX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_stream_arbiter_if.sv
// Request/grant bundle between the stream sources and the weighted round-robin arbiter.
interface wrr_stream_arbiter_if #(
  parameter int STREAM_COUNT = 4,
  parameter int WEIGHT_W     = 4,
  parameter int IDX_W        = $clog2(STREAM_COUNT)
);

  logic [STREAM_COUNT-1:0]          req;
  logic [STREAM_COUNT*WEIGHT_W-1:0] qos;
  logic                             xfer;
  logic                             last;
  logic [STREAM_COUNT-1:0]          grant;
  logic [IDX_W-1:0]                 grant_idx;
  logic                             busy;

  modport master (
    output req, qos, xfer, last,
    input  grant, grant_idx, busy
  );

  modport slave (
    input  req, qos, xfer, last,
    output grant, grant_idx, busy
  );

endinterface

// File: rtl/wrr_stream_arbiter_prio.sv
// Fixed-priority picker: one-hot grant of the lowest-indexed set request bit.
module simple_priority_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + N'(1));

endmodule

// File: rtl/wrr_stream_arbiter.sv
// Weighted round-robin arbiter over N streams; a grant is held for a whole packet
// and the next packet is arbitrated in the cycle the current one finishes.
module wrr_stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter int STREAM_COUNT = 4,
  parameter int WEIGHT_W     = 4,
  parameter int IDX_W        = $clog2(STREAM_COUNT)
) (
  input logic                 clk,
  input logic                 nrst,
  wrr_stream_arbiter_if.slave bus
);

  localparam logic [STREAM_COUNT-1:0] PTR_RESET = {1'b1, {(STREAM_COUNT-1){1'b0}}};
  localparam logic [WEIGHT_W-1:0]     CREDIT_ZERO = {WEIGHT_W{1'b0}};

  arb_state_t                state_r, state_nxt_s;
  logic [STREAM_COUNT-1:0]   grant_r, grant_nxt_s;
  logic [IDX_W-1:0]          grant_idx_r, grant_idx_nxt_s;
  logic [STREAM_COUNT-1:0]   ptr_r, ptr_nxt_s;
  logic [WEIGHT_W-1:0]       credit_r     [STREAM_COUNT];
  logic [WEIGHT_W-1:0]       credit_dec_s [STREAM_COUNT];
  logic [WEIGHT_W-1:0]       credit_nxt_s [STREAM_COUNT];
  logic [WEIGHT_W-1:0]       weight_s     [STREAM_COUNT];

  logic [STREAM_COUNT-1:0]   elig_s;
  logic [STREAM_COUNT-1:0]   pool_s;
  logic [STREAM_COUNT-1:0]   mask_s;
  logic [STREAM_COUNT-1:0]   masked_pool_s;
  logic [STREAM_COUNT-1:0]   pick_masked_s;
  logic [STREAM_COUNT-1:0]   pick_unmasked_s;
  logic [STREAM_COUNT-1:0]   pick_s;
  logic [IDX_W-1:0]          pick_idx_s;
  logic                      finish_s;
  logic                      arb_s;
  logic                      reload_s;

  // Post-completion credit, normalized weights and the eligible set.
  always_comb begin
    finish_s = (state_r == LOCKED) && bus.xfer && bus.last;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      weight_s[i] = bus.qos[i*WEIGHT_W +: WEIGHT_W];
      if (weight_s[i] == CREDIT_ZERO) begin
        weight_s[i] = WEIGHT_W'(WEIGHT_ZERO_LOAD);
      end else begin
        weight_s[i] = bus.qos[i*WEIGHT_W +: WEIGHT_W];
      end
      if (finish_s && grant_r[i] && (credit_r[i] != CREDIT_ZERO)) begin
        credit_dec_s[i] = credit_r[i] - WEIGHT_W'(1);
      end else begin
        credit_dec_s[i] = credit_r[i];
      end
      elig_s[i] = bus.req[i] && (credit_dec_s[i] != CREDIT_ZERO);
    end
  end

  // Arbitration trigger, round reload and the candidate pool.
  always_comb begin
    arb_s    = ((state_r == IDLE) || finish_s) && (|bus.req);
    reload_s = arb_s && (elig_s == {STREAM_COUNT{1'b0}});
    pool_s   = reload_s ? bus.req : elig_s;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      credit_nxt_s[i] = reload_s ? weight_s[i] : credit_dec_s[i];
    end
  end

  // Keep only streams strictly after the pointer; fall back to the full pool on wrap.
  assign mask_s        = ~(ptr_r | (ptr_r - STREAM_COUNT'(1)));
  assign masked_pool_s = pool_s & mask_s;

  simple_priority_arbiter #(.N(STREAM_COUNT)) u_pick_masked (
    .req   (masked_pool_s),
    .grant (pick_masked_s)
  );

  simple_priority_arbiter #(.N(STREAM_COUNT)) u_pick_unmasked (
    .req   (pool_s),
    .grant (pick_unmasked_s)
  );

  assign pick_s     = (|masked_pool_s) ? pick_masked_s : pick_unmasked_s;
  assign pick_idx_s = IDX_W'(onehot_to_idx(MAX_STREAMS'(pick_s)));

  // Next-state and grant decode.
  always_comb begin
    state_nxt_s     = state_r;
    grant_nxt_s     = grant_r;
    grant_idx_nxt_s = grant_idx_r;
    ptr_nxt_s       = ptr_r;
    case (state_r)
      IDLE: begin
        if (arb_s) begin
          state_nxt_s     = LOCKED;
          grant_nxt_s     = pick_s;
          grant_idx_nxt_s = pick_idx_s;
          ptr_nxt_s       = pick_s;
        end else begin
          state_nxt_s     = IDLE;
          grant_nxt_s     = {STREAM_COUNT{1'b0}};
          grant_idx_nxt_s = {IDX_W{1'b0}};
        end
      end
      LOCKED: begin
        if (arb_s) begin
          state_nxt_s     = LOCKED;
          grant_nxt_s     = pick_s;
          grant_idx_nxt_s = pick_idx_s;
          ptr_nxt_s       = pick_s;
        end else if (finish_s) begin
          state_nxt_s     = IDLE;
          grant_nxt_s     = {STREAM_COUNT{1'b0}};
          grant_idx_nxt_s = {IDX_W{1'b0}};
        end else begin
          state_nxt_s     = LOCKED;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        grant_nxt_s     = {STREAM_COUNT{1'b0}};
        grant_idx_nxt_s = {IDX_W{1'b0}};
        ptr_nxt_s       = PTR_RESET;
      end
    endcase
  end

  // State, grant, pointer and credit registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= IDLE;
      grant_r     <= {STREAM_COUNT{1'b0}};
      grant_idx_r <= {IDX_W{1'b0}};
      ptr_r       <= PTR_RESET;
      for (int i = 0; i < STREAM_COUNT; i++) begin
        credit_r[i] <= CREDIT_ZERO;
      end
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      grant_idx_r <= grant_idx_nxt_s;
      ptr_r       <= ptr_nxt_s;
      for (int i = 0; i < STREAM_COUNT; i++) begin
        credit_r[i] <= credit_nxt_s[i];
      end
    end
  end

  assign bus.grant     = grant_r;
  assign bus.grant_idx = grant_idx_r;
  assign bus.busy      = (state_r == LOCKED);

endmodule

// File: tb/tb_wrr_stream_arbiter.sv
// Directed self-checking bench for wrr_stream_arbiter (N=4, WEIGHT_W=4).
module tb_wrr_stream_arbiter;

  logic clk;
  logic nrst;
  int   errors;
  int   checks;

  wrr_stream_arbiter_if #(.STREAM_COUNT(4), .WEIGHT_W(4)) ifc ();

  wrr_stream_arbiter #(.STREAM_COUNT(4), .WEIGHT_W(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input int idx);
    chk({tag, ".grant"}, 32'(ifc.grant), 32'(1) << idx);
    chk({tag, ".idx"}, 32'(ifc.grant_idx), 32'(idx));
    chk({tag, ".busy"}, 32'(ifc.busy), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, 32'(ifc.grant), 32'd0);
    chk({tag, ".busy"}, 32'(ifc.busy), 32'd0);
  endtask

  task automatic do_reset();
    nrst     = 1'b0;
    ifc.req  = 4'b0000;
    ifc.xfer = 1'b0;
    ifc.last = 1'b0;
    step();
    step();
    nrst = 1'b1;
  endtask

  int exp_eq[6] = '{0, 1, 2, 3, 0, 1};
  int exp_w[11] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0};

  initial begin
    errors   = 0;
    checks   = 0;
    nrst     = 1'b0;
    ifc.req  = 4'b0000;
    ifc.qos  = 16'h1111;
    ifc.xfer = 1'b0;
    ifc.last = 1'b0;

    // Reset state, then a single request.
    #3;
    chk_idle("reset");
    chk("reset.idx", 32'(ifc.grant_idx), 32'd0);
    step();
    nrst    = 1'b1;
    ifc.req = 4'b0001;
    step();
    chk_grant("single", 0);
    ifc.req  = 4'b0000;
    ifc.xfer = 1'b1;
    ifc.last = 1'b1;
    step();
    chk_idle("single_end");

    // Equal weights, single-beat packets, no idle cycles.
    do_reset();
    ifc.qos  = 16'h1111;
    ifc.req  = 4'b1111;
    ifc.xfer = 1'b1;
    ifc.last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_grant($sformatf("equal%0d", i), exp_eq[i]);
    end

    // Weighted: stream0 weight 3, others 1.
    do_reset();
    ifc.qos  = 16'h1113;
    ifc.req  = 4'b1111;
    ifc.xfer = 1'b1;
    ifc.last = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      chk_grant($sformatf("weighted%0d", i), exp_w[i]);
    end

    // Packet lock over a 4-beat packet with a last-without-xfer stall.
    do_reset();
    ifc.qos = 16'h1111;
    ifc.req = 4'b0010;
    step();
    chk_grant("lock_start", 1);
    ifc.req  = 4'b0110;
    ifc.xfer = 1'b1;
    ifc.last = 1'b0;
    step();
    chk_grant("lock_beat1", 1);
    ifc.req = 4'b0100;
    step();
    chk_grant("lock_beat2", 1);
    ifc.xfer = 1'b0;
    ifc.last = 1'b1;
    step();
    chk_grant("lock_stall", 1);
    ifc.xfer = 1'b1;
    ifc.last = 1'b0;
    step();
    chk_grant("lock_beat3", 1);
    ifc.last = 1'b1;
    step();
    chk_grant("lock_next", 2);
    ifc.req = 4'b0000;
    step();
    chk_idle("lock_end");

    // Weight zero on stream2 behaves as weight 1, then idle return.
    do_reset();
    ifc.qos  = 16'h1011;
    ifc.req  = 4'b0100;
    ifc.xfer = 1'b1;
    ifc.last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_grant($sformatf("wzero%0d", i), 2);
    end
    ifc.req = 4'b0000;
    step();
    chk_idle("wzero_end");

    // Asynchronous reset in the middle of a packet.
    do_reset();
    ifc.qos = 16'h1111;
    ifc.req = 4'b0001;
    step();
    chk_grant("async_pre", 0);
    #2;
    nrst = 1'b0;
    #1;
    chk_idle("async_mid");
    step();
    ifc.req = 4'b1000;
    step();
    chk_idle("async_held");
    nrst = 1'b1;
    step();
    chk_grant("async_post", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrr_stream_arbiter.md
# wrr_stream_arbiter

Packet-locked weighted round-robin arbiter for N input streams, sitting between the stream sources and the shared output mux of the QoS stream arbiter. Each stream has a programmable QoS weight that sets how many packets it may win per arbitration round. A grant, once issued, is held for a whole packet until its final beat is transferred. The grant is registered, and back-to-back packets are arbitrated without bubble cycles.

## Interface
- STREAM_COUNT, 4: number of streams N, ≥2
- WEIGHT_W, 4: width of each QoS weight
- IDX_W, $clog2(STREAM_COUNT): width of grant_idx
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- req  in  N  per-stream request, level
- qos  in  N*WEIGHT_W  packed weights; stream i at [i*WEIGHT_W +: WEIGHT_W]
- xfer  in  1  a beat of the granted stream is accepted this cycle
- last  in  1  the accepted beat is the final beat of the packet; qualified by xfer
- grant  out  N  one-hot grant, registered
- grant_idx  out  IDX_W  binary index of grant; valid when busy
- busy  out  1  a packet is currently granted

## Operation
- States: IDLE, LOCKED (busy = LOCKED).
- **Credits**
  - Per-stream credit counters, WEIGHT_W bits wide.
  - Eligible set is req & (credit != 0).
- **Selection**
  - Round-robin over the eligible set, starting at the stream after ptr_r, wrapping from N-1 to 0.
  - ptr_r is one-hot and resets to stream N-1, so stream 0 is first after reset.
- **Reload**
  - Triggered when |req and the eligible set is empty.
  - Every credit is loaded with its qos weight; a weight of 0 loads as 1.
  - Selection then runs over all of req in the same cycle.
- **IDLE**
  - If |req: load grant/grant_idx with the pick, set ptr_r to the pick, go to LOCKED.
  - Otherwise hold; grant stays 0.
- **LOCKED**
  - Grant is held regardless of req changes.
  - On xfer & last: decrement the granted stream's credit, floored at 0.
  - Re-selection in that same cycle uses the post-decrement credit value.
  - If |req: the new grant loads next cycle and the state stays LOCKED.
  - Else: grant clears and the state goes to IDLE.
- last without xfer is ignored. xfer in IDLE is ignored.
- Interleaved WRR: a stream with remaining credit does not get consecutive grants while other eligible streams wait.
- Weights are sampled only at reload. A qos change mid-round takes effect at the next reload.

## Timing
- **Reset** (asynchronous, immediate):
  - grant = 0, grant_idx = 0, busy = 0
  - state IDLE, all credits 0, ptr_r = one-hot N-1
  - Reset mid-packet drops the grant immediately, with no last required.
  - The first arbitration after reset always reloads credits.
- **Latency**
  - req rising in IDLE → grant asserted at the next rising edge (1 cycle).
  - xfer & last → next grant at the next rising edge, with no bubble if any req is pending.
- **Simultaneous events**
  - Reload and credit decrement in the same cycle: the reload wins; the finishing stream's credit reloads to its weight.
  - The finishing stream may be re-picked if it is the only requester.

## Structure
- Package stream_arb_pkg holds:
  - the state enum typedef (IDLE, LOCKED)
  - a function one-hot→index
  - the weight-0→1 normalization constant
- Sub-module: reuse simple_priority_arbiter twice, as the masked and unmasked pick over the rotated eligible vector.
- Credit counters, FSM and ptr_r live in wrr_stream_arbiter.

## Test plan
All scenarios use N=4, WEIGHT_W=4; single-beat packets mean xfer=last=1 every LOCKED cycle.
- **Reset then single request:** nrst low → grant=0, busy=0. Release, req=0001 → grant=0001, grant_idx=0, busy=1 one cycle later.
- **Equal weights:** qos all 1, req=1111 held, single-beat packets → grant sequence 0,1,2,3,0,1 with no idle cycles.
- **Weighted:** qos={1,1,1,3} (stream0=3), req=1111, single-beat packets → sequence 0,1,2,3,0,0,1,2,3,0,0; stream0 takes 3 of every 6 packets.
- **Packet lock:**
  - Stream 1 granted on a 4-beat packet; req[1] drops after beat 1 while req=0100.
  - grant stays 0010 until xfer&last on beat 4, then becomes 0100 next cycle.
  - xfer without last never releases the grant.
- **Weight zero, idle return:**
  - qos stream2=0, req=0100 repeatedly → stream2 is granted every packet (treated as weight 1).
  - After its last with req=0 → grant=0, busy=0 next cycle.
- **Async reset mid-packet:**
  - Assert nrst mid-cycle during a LOCKED packet → grant=0 and busy=0 immediately, before the next edge.
  - After release with req=1000 → grant=1000 one cycle later, following a fresh reload.
